// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
// Defines the FSM state encoding, bus widths and the half-word select helper.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_sel_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          SRAM_DW           = 16;
    localparam int          CPU_DW            = 32;
    localparam int          CNT_W             = 4;

    function automatic logic [SRAM_DW-1:0] half_of(input logic [CPU_DW-1:0] w,
                                                   input half_sel_t         h);
        return (h == HALF_HI) ? w[CPU_DW-1:SRAM_DW] : w[SRAM_DW-1:0];
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable down-counter timing one half-word phase; tc is high on the phase's
// last cycle (count == 0).
module sram_phase_counter
    import sram_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit load/store requests onto a 16-bit asynchronous SRAM as two
// timed half-word phases. Optional macro SRAM_ADDR_CHECK_EN adds addr_err.
module sram_controller
    import sram_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [CPU_DW-1:0]  address,
    input  logic [CPU_DW-1:0]  write_data,
    output logic [CPU_DW-1:0]  read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int              WORD_W     = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t             state_q, state_d;
    logic               is_wr_q;
    logic [WORD_W-1:0]  word_q;
    logic [CPU_DW-1:0]  wdata_q;
    logic               req;
    logic               accept;
    logic               addr_bad;
    logic [CPU_DW-1:0]  offset;
    logic [WORD_W-1:0]  word_in;
    logic               cnt_load, cnt_en, cnt_tc;
    half_sel_t          half;

    assign req     = rd_en | wr_en;
    assign accept  = (state_q == IDLE) && req;
    assign offset  = address - BASE_ADDR;
    assign word_in = WORD_W'(offset >> 2);

`ifdef SRAM_ADDR_CHECK_EN
    logic err_q;
    // Out-of-window or misaligned requests skip the SRAM entirely.
    assign addr_bad = (address < BASE_ADDR) || (address[1:0] != 2'b00) ||
                      (offset[CPU_DW-1:SRAM_AW+1] != '0);
    assign addr_err = (state_q == DONE) && err_q;
`else
    assign addr_bad = 1'b0;
`endif

    sram_phase_counter #(.WIDTH(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (PHASE_LOAD),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        half        = HALF_LO;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d  = addr_bad ? DONE : LOW;
                    cnt_load = 1'b1;
                end
            end
            LOW, HIGH: begin
                half        = (state_q == HIGH) ? HALF_HI : HALF_LO;
                cnt_en      = 1'b1;
                sram_addr   = {word_q, half};
                sram_dq_out = is_wr_q ? half_of(wdata_q, half) : '0;
                sram_dq_oe  = is_wr_q;
                sram_we_n   = ~is_wr_q;
                if (cnt_tc) begin
                    state_d  = (state_q == LOW) ? HIGH : DONE;
                    cnt_load = 1'b1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches and read assembly; SRAM data is captured on each phase's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                is_wr_q <= wr_en;
                word_q  <= word_in;
                wdata_q <= write_data;
`ifdef SRAM_ADDR_CHECK_EN
                err_q   <= addr_bad;
                if (addr_bad && !wr_en) begin
                    read_data <= '0;
                end
`endif
            end
            if (state_q == LOW && cnt_tc && !is_wr_q) begin
                read_data[SRAM_DW-1:0] <= sram_dq_in;
            end
            if (state_q == HIGH && cnt_tc && !is_wr_q) begin
                read_data[CPU_DW-1:SRAM_DW] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: directed vector table, reset-abort and back-to-back
// sequences, then randomized transfers against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        use1;
    logic        rd_i, wr_i;
    logic [31:0] addr_i, wd_i;

    logic        rd3, wr3, rd1, wr1;
    logic [31:0] rdata3, rdata1;
    logic        ready3, ready1;
    logic [17:0] sa3, sa1;
    logic [15:0] dqo3, dqo1, dqi3, dqi1;
    logic        oe3, oe1, we3, we1;

    assign rd3 = rd_i & ~use1;
    assign wr3 = wr_i & ~use1;
    assign rd1 = rd_i & use1;
    assign wr1 = wr_i & use1;

`ifdef SRAM_ADDR_CHECK_EN
    logic err3, err1, o_err;
    assign o_err = use1 ? err1 : err3;
`endif

    sram_controller #(.ACCESS_CYCLES(3), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut3 (
        .clk(clk), .rst(rst), .rd_en(rd3), .wr_en(wr3), .address(addr_i),
        .write_data(wd_i), .read_data(rdata3), .ready(ready3), .sram_addr(sa3),
        .sram_dq_out(dqo3), .sram_dq_in(dqi3), .sram_dq_oe(oe3), .sram_we_n(we3)
`ifdef SRAM_ADDR_CHECK_EN
        , .addr_err(err3)
`endif
    );

    sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr_i),
        .write_data(wd_i), .read_data(rdata1), .ready(ready1), .sram_addr(sa1),
        .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1)
`ifdef SRAM_ADDR_CHECK_EN
        , .addr_err(err1)
`endif
    );

    logic [31:0] o_rdata;
    logic        o_ready, o_oe, o_we;
    logic [17:0] o_addr;
    logic [15:0] o_dqo;
    assign o_rdata = use1 ? rdata1 : rdata3;
    assign o_ready = use1 ? ready1 : ready3;
    assign o_oe    = use1 ? oe1 : oe3;
    assign o_we    = use1 ? we1 : we3;
    assign o_addr  = use1 ? sa1 : sa3;
    assign o_dqo   = use1 ? dqo1 : dqo3;

    // SRAM environment for dut3: asynchronous read, write while we_n is low.
    logic [15:0] sram_mem [0:1023];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 16'h0;
            sram_mem[4] <= 16'h1234;
            sram_mem[5] <= 16'hABCD;
        end else if (!we3) begin
            sram_mem[sa3[9:0]] <= dqo3;
        end
    end
    assign dqi3 = sram_mem[sa3[9:0]];
    // dut1 sees a fixed address-derived pattern.
    assign dqi1 = sa1[15:0] ^ 16'h5A3C;

    // Reference model state.
    logic [15:0] ref_mem [0:1023];
    logic [31:0] prev3, prev1;
    int          n_tests, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hw_val(input int hw, input bit one);
        if (one) return 16'(hw) ^ 16'h5A3C;
        return ref_mem[hw];
    endfunction

    // One transfer, entered at a negedge; checks every cycle from request to DONE.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] got);
        int          n;
        longint      off;
        bit          flagged;
        int          word, len;
        logic [31:0] exp_rd;
        n       = use1 ? 1 : 3;
        off     = longint'(a) - 64'sd1024;
        flagged = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
        flagged = (off < 0) || (a[1:0] != 2'b00) || ((off >>> 2) >= (64'sd1 << 17));
`endif
        word = int'((off >>> 2) & 64'h1FFFF);
        if (wr)           exp_rd = use1 ? prev1 : prev3;
        else if (flagged) exp_rd = 32'h0;
        else              exp_rd = {hw_val(2*word+1, use1), hw_val(2*word, use1)};
        len = flagged ? 2 : 2*n + 2;
        got = 32'h0;

        rd_i = rd; wr_i = wr; addr_i = a; wd_i = wd;
        for (int k = 0; k < len; k++) begin
            #1;
            check("ready", {31'h0, o_ready}, {31'h0, k == len-1});
            if (!flagged && k >= 1 && k <= 2*n) begin
                bit hi;
                hi = (k > n);
                check("sram_addr", {14'h0, o_addr}, 32'(2*word + int'(hi)));
                check("we_n", {31'h0, o_we}, {31'h0, !wr});
                check("oe", {31'h0, o_oe}, {31'h0, wr});
                if (wr) check("dq_out", {16'h0, o_dqo}, {16'h0, hi ? wd[31:16] : wd[15:0]});
            end else begin
                check("idle_we_n", {31'h0, o_we}, 32'h1);
                check("idle_oe", {31'h0, o_oe}, 32'h0);
            end
`ifdef SRAM_ADDR_CHECK_EN
            check("addr_err", {31'h0, o_err}, {31'h0, flagged && (k == len-1)});
`endif
            if (k == len-1) begin
                check("read_data", o_rdata, exp_rd);
                got = o_rdata;
            end
            @(negedge clk);
        end
        rd_i = 1'b0; wr_i = 1'b0;

        if (!use1 && wr && !flagged) begin
            ref_mem[2*word]   = wd[15:0];
            ref_mem[2*word+1] = wd[31:16];
        end
        if (use1) prev1 = exp_rd;
        else      prev3 = exp_rd;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] got;

    initial begin
        n_tests = 0; n_fail = 0;
        use1 = 1'b0; rd_i = 1'b0; wr_i = 1'b0; addr_i = '0; wd_i = '0;
        rst = 1'b1; mem_init = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
        ref_mem[4] = 16'h1234;
        ref_mem[5] = 16'hABCD;
        prev3 = 32'h0; prev1 = 32'h0;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hABCD_1234};
        vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h00FF00FF, 32'hABCD_1234};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h00FF_00FF};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEAD_BEEF};
`ifdef SRAM_ADDR_CHECK_EN
        vecs[5] = '{1'b1, 1'b0, 32'd1025, 32'h0,        32'h0000_0000};
`else
        vecs[5] = '{1'b1, 1'b0, 32'd1025, 32'h0,        32'hDEAD_BEEF};
`endif

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {31'h0, ready3}, 32'h1);
        check("rst_we_n", {31'h0, we3}, 32'h1);
        check("rst_oe", {31'h0, oe3}, 32'h0);
        check("rst_addr", {14'h0, sa3}, 32'h0);
        check("rst_dq_out", {16'h0, dqo3}, 32'h0);
        check("rst_read_data", rdata3, 32'h0);
        check("rst_read_data1", rdata1, 32'h0);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got);
            check("tbl_rdata", got, vecs[i].exp_rdata);
        end
        check("mem_hw0", {16'h0, sram_mem[0]}, 32'hBEEF);
        check("mem_hw1", {16'h0, sram_mem[1]}, 32'hDEAD);
        check("mem_hw2", {16'h0, sram_mem[2]}, 32'h00FF);
        check("mem_hw3", {16'h0, sram_mem[3]}, 32'h00FF);

`ifdef SRAM_ADDR_CHECK_EN
        run_txn(1'b1, 1'b0, 32'd1022, 32'h0, got);
        check("err_rdata", got, 32'h0);
`endif

        // Reset during the HIGH phase of a store to half-words 2 and 3.
        wr_i = 1'b1; addr_i = 32'd1028; wd_i = 32'h1111_2222;
        repeat (4) @(negedge clk);
        #1;
        check("abort_pre_we_n", {31'h0, we3}, 32'h0);
        check("abort_pre_addr", {14'h0, sa3}, 32'h3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_i = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready3}, 32'h1);
        check("abort_we_n", {31'h0, we3}, 32'h1);
        check("abort_oe", {31'h0, oe3}, 32'h0);
        check("abort_addr", {14'h0, sa3}, 32'h0);
        check("abort_rdata", rdata3, 32'h0);
        check("abort_hw2", {16'h0, sram_mem[2]}, 32'h2222);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort_post_we_n", {31'h0, we3}, 32'h1);
        end
        @(negedge clk);
        prev3 = 32'h0;
        ref_mem[2] = 16'h2222;

        // Back-to-back loads with a one-cycle phase.
        use1 = 1'b1;
        run_txn(1'b1, 1'b0, 32'd1024 + 32'd28, 32'h0, got);
        check("b2b_first", got, 32'h5A33_5A32);
        run_txn(1'b1, 1'b0, 32'd1024 + 32'd36, 32'h0, got);
        check("b2b_second", got, 32'h5A2F_5A2E);
        use1 = 1'b0;
        @(negedge clk);

        // Randomized traffic on words 2..63.
        for (int i = 0; i < 24; i++) begin
            logic        r_wr, r_rd;
            logic [31:0] r_a;
            r_wr = 1'($urandom_range(0, 1));
            r_rd = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            r_a  = 32'd1024 + 32'(4 * $urandom_range(2, 63)) + 32'($urandom_range(0, 3));
            run_txn(r_rd, r_wr, r_a, $urandom, got);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
